// File: rtl/t03_dpu_frame_sync_if.sv
// CPU-side write bus for the DPU frame-synchronous register block.
// The requester holds wr_en/addr/wdata until it sees a one-cycle ack.
interface t03_dpu_frame_sync_if;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;

   modport master (output wr_en, output addr, output wdata, input ack);
   modport slave  (input wr_en, input addr, input wdata, output ack);
endinterface

// File: rtl/t03_dpu_frame_sync.sv
// Shadow/active register controller for the DPU: CPU writes land in shadow
// registers and are copied to the active set only at the start of vblank after a commit.
module t03_dpu_frame_sync #(
   parameter logic [31:0] BASE_ADDR   = 32'hFF000000,
   parameter logic [10:0] VBLANK_LINE = 11'd600,
   parameter logic [3:0]  HEALTH_INIT = 4'd9,
   parameter logic [10:0] X1_INIT     = 11'd100,
   parameter logic [10:0] X2_INIT     = 11'd500,
   parameter logic [10:0] X_MAX       = 11'd639,
   parameter logic [10:0] Y_MAX       = 11'd500
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [10:0]            Vcnt,
   t03_dpu_frame_sync_if.slave    bus,
   output logic                   busy,
   output logic [2:0]             gameState,
   output logic [1:0]             p1State,
   output logic [1:0]             p2State,
   output logic [3:0]             p1health,
   output logic [3:0]             p2health,
   output logic [10:0]            x1,
   output logic [10:0]            x2,
   output logic [10:0]            y1,
   output logic [10:0]            y2,
   output logic                   p1Left,
   output logic                   p2Left,
   output logic                   commit_done,
   output logic [7:0]             frame_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

   localparam logic [3:0] OFF_GAME   = 4'd0;
   localparam logic [3:0] OFF_COMMIT = 4'd5;

   state_t      state_q;
   logic        ack_q;
   logic        busy_q;
   logic        commit_done_q;
   logic [7:0]  frame_count_q;
   logic [10:0] vcnt_prev_q;

   logic [2:0]  sh_game_q;
   logic [2:0]  act_game_q;

   logic        hit;
   logic        accept;
   logic        vblank_start;
   logic        do_copy;
   logic [3:0]  offset;
   logic [3:0]  health_d;
   logic [10:0] x_d;
   logic [10:0] y_d;
   logic        unused_wdata;

   assign offset       = bus.addr[3:0];
   assign hit          = (bus.addr[31:4] == BASE_ADDR[31:4]);
   // The !ack_q term keeps a held request from being written twice.
   assign accept       = bus.wr_en && hit && (state_q == ST_IDLE) && !ack_q;
   assign vblank_start = (Vcnt == VBLANK_LINE) && (vcnt_prev_q != VBLANK_LINE);
   assign do_copy      = (state_q == ST_PENDING) && vblank_start;

   assign health_d = (bus.wdata[5:2] > HEALTH_INIT) ? HEALTH_INIT : bus.wdata[5:2];
   assign x_d      = (bus.wdata[10:0] > X_MAX) ? X_MAX : bus.wdata[10:0];
   assign y_d      = (bus.wdata[26:16] > Y_MAX) ? Y_MAX : bus.wdata[26:16];

   assign unused_wdata = ^{bus.wdata[31:27], bus.wdata[15:11]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ack_q         <= 1'b0;
         busy_q        <= 1'b0;
         commit_done_q <= 1'b0;
         frame_count_q <= 8'd0;
         vcnt_prev_q   <= 11'd0;
      end else begin
         ack_q       <= accept;
         vcnt_prev_q <= Vcnt;
         if (vblank_start) begin
            frame_count_q <= frame_count_q + 8'd1;
         end
         case (state_q)
            ST_IDLE: begin
               commit_done_q <= 1'b0;
               if (accept && (offset == OFF_COMMIT)) begin
                  state_q <= ST_PENDING;
                  busy_q  <= 1'b1;
               end
            end
            ST_PENDING: begin
               if (vblank_start) begin
                  state_q       <= ST_COMMIT;
                  commit_done_q <= 1'b1;
               end
            end
            ST_COMMIT: begin
               state_q       <= ST_IDLE;
               busy_q        <= 1'b0;
               commit_done_q <= 1'b0;
            end
            default: begin
               state_q       <= ST_IDLE;
               busy_q        <= 1'b0;
               commit_done_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_game_q  <= 3'd0;
         act_game_q <= 3'd0;
      end else begin
         if (accept && (offset == OFF_GAME)) begin
            sh_game_q <= bus.wdata[2:0];
         end
         if (do_copy) begin
            act_game_q <= sh_game_q;
         end
      end
   end

   // Player 0 owns offsets 1/3, player 1 owns offsets 2/4.
   for (genvar gi = 0; gi < 2; gi++) begin : g_player
      localparam logic [3:0]  ST_OFF   = 4'(gi + 1);
      localparam logic [3:0]  POS_OFF  = 4'(gi + 3);
      localparam logic [10:0] X_RST    = (gi == 0) ? X1_INIT : X2_INIT;
      localparam logic        LEFT_RST = (gi == 1);

      logic [1:0]  sh_state_q,  act_state_q;
      logic [3:0]  sh_health_q, act_health_q;
      logic        sh_left_q,   act_left_q;
      logic [10:0] sh_x_q,      act_x_q;
      logic [10:0] sh_y_q,      act_y_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            sh_state_q   <= 2'd0;
            sh_health_q  <= HEALTH_INIT;
            sh_left_q    <= LEFT_RST;
            sh_x_q       <= X_RST;
            sh_y_q       <= 11'd0;
            act_state_q  <= 2'd0;
            act_health_q <= HEALTH_INIT;
            act_left_q   <= LEFT_RST;
            act_x_q      <= X_RST;
            act_y_q      <= 11'd0;
         end else begin
            if (accept && (offset == ST_OFF)) begin
               sh_state_q  <= bus.wdata[1:0];
               sh_health_q <= health_d;
               sh_left_q   <= bus.wdata[6];
            end
            if (accept && (offset == POS_OFF)) begin
               sh_x_q <= x_d;
               sh_y_q <= y_d;
            end
            if (do_copy) begin
               act_state_q  <= sh_state_q;
               act_health_q <= sh_health_q;
               act_left_q   <= sh_left_q;
               act_x_q      <= sh_x_q;
               act_y_q      <= sh_y_q;
            end
         end
      end
   end

   assign bus.ack     = ack_q;
   assign busy        = busy_q;
   assign commit_done = commit_done_q;
   assign frame_count = frame_count_q;
   assign gameState   = act_game_q;

   assign p1State  = g_player[0].act_state_q;
   assign p2State  = g_player[1].act_state_q;
   assign p1health = g_player[0].act_health_q;
   assign p2health = g_player[1].act_health_q;
   assign p1Left   = g_player[0].act_left_q;
   assign p2Left   = g_player[1].act_left_q;
   assign x1       = g_player[0].act_x_q;
   assign x2       = g_player[1].act_x_q;
   assign y1       = g_player[0].act_y_q;
   assign y2       = g_player[1].act_y_q;

endmodule

// File: tb/tb_t03_dpu_frame_sync.sv
// Directed bench for t03_dpu_frame_sync: steps happen at the falling edge,
// so outputs are sampled half a cycle after the edge that produced them.
module tb_t03_dpu_frame_sync;

   localparam logic [31:0] BASE = 32'hFF000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] Vcnt;
   logic        busy;
   logic [2:0]  gameState;
   logic [1:0]  p1State, p2State;
   logic [3:0]  p1health, p2health;
   logic [10:0] x1, x2, y1, y2;
   logic        p1Left, p2Left;
   logic        commit_done;
   logic [7:0]  frame_count;

   int n_total = 0;
   int n_pass  = 0;

   t03_dpu_frame_sync_if bus_if ();

   t03_dpu_frame_sync dut (
      .clk         (clk),
      .rst         (rst),
      .Vcnt        (Vcnt),
      .bus         (bus_if.slave),
      .busy        (busy),
      .gameState   (gameState),
      .p1State     (p1State),
      .p2State     (p2State),
      .p1health    (p1health),
      .p2health    (p2health),
      .x1          (x1),
      .x2          (x2),
      .y1          (y1),
      .y2          (y2),
      .p1Left      (p1Left),
      .p2Left      (p2Left),
      .commit_done (commit_done),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One bus write: ack must be seen on the first sampled cycle.
   task automatic bus_write(input string tag, input logic [3:0] off, input logic [31:0] data);
      bus_if.wr_en = 1'b1;
      bus_if.addr  = BASE | {28'd0, off};
      bus_if.wdata = data;
      step(1);
      chk(tag, bus_if.ack, 1'b1);
      bus_if.wr_en = 1'b0;
      step(1);
   endtask

   // Vcnt 599 -> 600 produces exactly one vblank_start.
   task automatic vblank_edge();
      Vcnt = 11'd599;
      step(1);
      Vcnt = 11'd600;
      step(1);
   endtask

   initial begin
      rst          = 1'b1;
      Vcnt         = 11'd0;
      bus_if.wr_en = 1'b0;
      bus_if.addr  = 32'd0;
      bus_if.wdata = 32'd0;
      step(3);
      rst = 1'b0;
      step(1);

      // Reset values
      chk("rst_p1health", p1health, 4'd9);
      chk("rst_p2health", p2health, 4'd9);
      chk("rst_x1", x1, 11'd100);
      chk("rst_x2", x2, 11'd500);
      chk("rst_p2Left", p2Left, 1'b1);
      chk("rst_p1Left", p1Left, 1'b0);
      chk("rst_frame_count", frame_count, 8'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack", bus_if.ack, 1'b0);

      // Write then commit: shadow only until vblank
      bus_if.wr_en = 1'b1;
      bus_if.addr  = BASE | 32'd3;
      bus_if.wdata = (32'd50 << 16) | 32'd200;
      step(1);
      chk("wr3_ack", bus_if.ack, 1'b1);
      chk("wr3_x1_unchanged", x1, 11'd100);
      bus_if.wr_en = 1'b0;
      step(1);
      chk("wr3_ack_drop", bus_if.ack, 1'b0);
      bus_write("commit1_ack", 4'd5, 32'd0);
      chk("commit1_busy", busy, 1'b1);
      chk("commit1_x1_pre", x1, 11'd100);
      vblank_edge();
      chk("commit1_done", commit_done, 1'b1);
      chk("commit1_x1", x1, 11'd200);
      chk("commit1_y1", y1, 11'd50);
      chk("commit1_busy_m1", busy, 1'b1);
      chk("commit1_frame", frame_count, 8'd1);
      step(1);
      chk("commit1_done_drop", commit_done, 1'b0);
      chk("commit1_busy_m2", busy, 1'b0);

      // Clamping on write
      bus_write("clamp_wr1_ack", 4'd1, 32'h0000007E);
      bus_write("clamp_wr4_ack", 4'd4, (32'd700 << 16) | 32'd2000);
      bus_write("clamp_commit_ack", 4'd5, 32'd0);
      vblank_edge();
      chk("clamp_done", commit_done, 1'b1);
      chk("clamp_p1health", p1health, 4'd9);
      chk("clamp_p1State", p1State, 2'd2);
      chk("clamp_p1Left", p1Left, 1'b1);
      chk("clamp_x2", x2, 11'd639);
      chk("clamp_y2", y2, 11'd500);
      chk("clamp_frame", frame_count, 8'd2);
      step(1);

      // Stall while pending
      bus_write("stall_commit_ack", 4'd5, 32'd0);
      bus_if.wr_en = 1'b1;
      bus_if.addr  = BASE | 32'd0;
      bus_if.wdata = 32'd3;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("stall_no_ack", bus_if.ack, 1'b0);
      end
      vblank_edge();
      chk("stall_done", commit_done, 1'b1);
      chk("stall_ack_in_commit", bus_if.ack, 1'b0);
      chk("stall_gs_old", gameState, 3'd0);
      step(1);
      chk("stall_ack_idle_first", bus_if.ack, 1'b0);
      chk("stall_busy_clear", busy, 1'b0);
      step(1);
      chk("stall_ack_after", bus_if.ack, 1'b1);
      bus_if.wr_en = 1'b0;
      step(1);
      chk("stall_gs_still_old", gameState, 3'd0);
      bus_write("stall_commit2_ack", 4'd5, 32'd0);
      vblank_edge();
      chk("stall_commit2_done", commit_done, 1'b1);
      chk("stall_gs_new", gameState, 3'd3);
      chk("stall_frame", frame_count, 8'd4);
      step(1);

      // Held wr_en to a no-effect offset: ack every other cycle
      bus_if.wr_en = 1'b1;
      bus_if.addr  = BASE | 32'd6;
      bus_if.wdata = 32'hFFFFFFFF;
      for (int i = 0; i < 6; i++) begin
         step(1);
         chk("held_ack_pattern", bus_if.ack, ((i % 2) == 0) ? 1'b1 : 1'b0);
      end
      bus_if.wr_en = 1'b0;
      step(1);
      chk("held_gs_unchanged", gameState, 3'd3);

      // Address miss is never acked
      bus_if.wr_en = 1'b1;
      bus_if.addr  = 32'h12345678;
      bus_if.wdata = 32'd7;
      for (int i = 0; i < 4; i++) begin
         step(1);
         chk("miss_no_ack", bus_if.ack, 1'b0);
      end
      bus_if.wr_en = 1'b0;
      step(1);

      // frame_count wraps: 4 + 251 = 255, one more -> 0
      for (int i = 0; i < 251; i++) begin
         Vcnt = 11'd0;
         step(1);
         Vcnt = 11'd600;
         step(1);
      end
      chk("frame_255", frame_count, 8'd255);
      Vcnt = 11'd0;
      step(1);
      Vcnt = 11'd600;
      step(1);
      chk("frame_wrap", frame_count, 8'd0);
      chk("frame_no_commit", commit_done, 1'b0);

      // Commit request in the vblank_start cycle defers one frame
      Vcnt = 11'd599;
      step(1);
      bus_if.wr_en = 1'b1;
      bus_if.addr  = BASE | 32'd5;
      Vcnt         = 11'd600;
      step(1);
      chk("defer_ack", bus_if.ack, 1'b1);
      chk("defer_busy", busy, 1'b1);
      chk("defer_no_done", commit_done, 1'b0);
      bus_if.wr_en = 1'b0;
      step(2);
      chk("defer_still_pending", busy, 1'b1);
      chk("defer_still_no_done", commit_done, 1'b0);
      vblank_edge();
      chk("defer_done", commit_done, 1'b1);
      chk("defer_frame", frame_count, 8'd2);
      step(2);

      // Reset while pending: no commit, reset values back
      bus_write("rstp_wr0_ack", 4'd0, 32'd5);
      bus_write("rstp_commit_ack", 4'd5, 32'd0);
      chk("rstp_busy", busy, 1'b1);
      Vcnt = 11'd0;
      step(1);
      rst  = 1'b1;
      Vcnt = 11'd600;
      step(1);
      chk("rstp_no_done", commit_done, 1'b0);
      chk("rstp_busy_clear", busy, 1'b0);
      chk("rstp_frame", frame_count, 8'd0);
      chk("rstp_gs", gameState, 3'd0);
      chk("rstp_x1", x1, 11'd100);
      rst  = 1'b0;
      Vcnt = 11'd0;
      step(1);
      Vcnt = 11'd600;
      step(1);
      chk("rstp_after_no_done", commit_done, 1'b0);
      chk("rstp_after_frame", frame_count, 8'd1);
      chk("rstp_after_gs", gameState, 3'd0);
      chk("rstp_after_p1health", p1health, 4'd9);
      chk("rstp_after_x2", x2, 11'd500);
      chk("rstp_after_p1Left", p1Left, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/t03_dpu_frame_sync.md
# t03_dpu_frame_sync

Frame-synchronous register controller for the team-03 display unit (DPU). Accepts CPU writes of game/player state over a simple req/ack bus into shadow registers and copies them into the active registers that drive the DPU inputs. The copy happens only at the start of vertical blanking after a commit request, so a frame is never drawn from a mix of old and new values. Sits between the CPU bus interface and the DPU top, and also supplies a frame counter and commit status.

## Interface
Parameters:
- BASE_ADDR, 32'hFF000000, register block base; a bus address hits when addr[31:4] == BASE_ADDR[31:4].
- VBLANK_LINE, 11'd600, Vcnt value marking the first blanking line.
- HEALTH_INIT, 4'd9, reset health for both players; also the clamp ceiling.
- X1_INIT, 11'd100; X2_INIT, 11'd500: reset x positions.
- X_MAX, 11'd639; Y_MAX, 11'd500: position clamp ceilings.

Ports:
- clk  in  1  system clock (DPU pixel clock domain).
- rst  in  1  reset; synchronous, active-high.
- Vcnt  in  11  vertical line count from the DPU vertical counter.
- wr_en  in  1  write request; held until ack.
- addr  in  32  write address.
- wdata  in  32  write data.
- ack  out  1  one-cycle write acknowledge.
- busy  out  1  high while a commit is pending.
- gameState  out  3  active game state.
- p1State, p2State  out  2 each  active player states.
- p1health, p2health  out  4 each  active health.
- x1, x2, y1, y2  out  11 each  active positions.
- p1Left, p2Left  out  1 each  active facing direction.
- commit_done  out  1  one-cycle pulse on the cycle the active registers update.
- frame_count  out  8  vblank-start counter; wraps 255->0.

## Operation
- Register map, offset = addr[3:0]:
  - 0: gameState = wdata[2:0].
  - 1: p1State = [1:0], p1health = [5:2], p1Left = [6].
  - 2: same as offset 1 for player 2.
  - 3: x1 = [10:0], y1 = [26:16].
  - 4: x2, y2, same layout as offset 3.
  - 5: commit request; data ignored.
  - 6-15: acked, no effect.
- Writes land in the shadow registers only. Clamp on write: health > HEALTH_INIT stores HEALTH_INIT; x > X_MAX stores X_MAX; y > Y_MAX stores Y_MAX.
- Address miss (outside BASE_ADDR): never acked, no effect; the requester must drop wr_en itself.
- FSM:
  - IDLE: accepts writes. A hit on offset 5 goes to PENDING.
  - PENDING: busy = 1. Writes are not accepted (no ack; wr_en may stay high and completes after the commit). On vblank_start, goes to COMMIT.
  - COMMIT (1 cycle): all active registers <= shadow; commit_done = 1; returns to IDLE.
- vblank_start = (Vcnt == VBLANK_LINE) && (Vcnt_prev != VBLANK_LINE), where Vcnt_prev is registered. frame_count increments on every vblank_start, in any FSM state.
- Reset, including mid-PENDING:
  - FSM to IDLE; ack, busy, commit_done = 0; frame_count = 0; Vcnt_prev = 0.
  - Shadow and active: gameState 0, states 0, health HEALTH_INIT, x1 X1_INIT, x2 X2_INIT, y 0, p1Left 0, p2Left 1.

## Timing
- Write accept: wr_en && hit && state IDLE && !ack at cycle N. The shadow updates at the N edge; ack = 1 in cycle N+1.
- wr_en is ignored in the cycle ack is high, so a held wr_en never double-writes. Minimum write spacing is 2 cycles.
- Commit request accepted in cycle N: busy = 1 from N+1.
- If vblank_start is detected in cycle M > N, commit_done = 1 and the active outputs change in cycle M+1; busy = 0 from M+2.
- A vblank_start in the same cycle as the commit-request accept does not commit; the commit waits for the next frame.
- All outputs are registered; the active outputs change only in the COMMIT cycle or on reset.
- A commit with no intervening writes still pulses commit_done; the outputs keep their values.

## Test plan
- Reset: after rst, p1health = p2health = 9, x1 = 100, x2 = 500, p2Left = 1, frame_count = 0, busy = 0, ack = 0.
- Write then commit: write offset 3 with x1 = 200, y1 = 50 -> ack one cycle later and x1 still 100. Write offset 5, then drive Vcnt 599->600 -> commit_done pulses and x1 = 200, y1 = 50 from the next cycle.
- Clamping: write offset 1 with health 15 and offset 4 with x = 2000, y = 700, then commit -> p1health = 9, x2 = 639, y2 = 500.
- Stall while pending: write a commit, then hold wr_en to offset 0 with gameState 3 -> no ack until after commit_done. gameState stays at its old value after this commit; a second commit then shows 3.
- Misc: held wr_en produces a single ack per 2 cycles. A miss address (0x12345678) is never acked. 256 vblank_starts wrap frame_count to 0. Commit request in the vblank_start cycle defers one frame. rst asserted during PENDING returns the block to the reset values with no commit_done.
